// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: pixel buffer feeding the vga timing stage (pixel_clk domain).
// Stores {sof,rgb} words from the frame source and hands one pixel per timing
// request, starting a frame only when the buffered data is aligned and deep enough.
// Underflow and frame misalignment are reported via sticky flags; misalignment
// flushes the buffer and re-hunts for the next start-of-frame word.
module vga_pixel_fifo #(
  parameter int DEPTH  = 256,
  parameter int DW     = 24,
  parameter int THRESH = 128
) (
  input  logic                         pixel_clk,
  input  logic                         pixel_rst_n,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_sof,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         pix_req,
  input  logic                         pix_sof,
  output logic [DW-1:0]                pix_rgb,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         underflow,
  output logic                         sync_err,
  input  logic                         err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] THRESH_L = LW'(THRESH);
  localparam logic [LW-1:0] FULL_L   = LW'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW:0]   head;
  logic          head_sof;
  logic [DW-1:0] head_data;

  logic          accept;
  logic          wr_en;
  logic          pop;
  logic          flush;
  logic          rgb_we;
  logic [DW-1:0] rgb_next;
  logic          set_uf;
  logic          set_se;

  assign head      = mem[rd_ptr];
  assign head_sof  = head[DW];
  assign head_data = head[DW-1:0];

  // While hunting for a frame start the source is never stalled; otherwise stall only when full.
  assign in_ready = (state == WAIT_SOF) || (level != FULL_L);
  assign accept   = in_valid && in_ready;

  // Next-state logic and per-cycle write/pop/flush/output decisions.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    rgb_we     = 1'b0;
    rgb_next   = '0;
    set_uf     = 1'b0;
    set_se     = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (accept && in_sof) begin
          wr_en      = 1'b1;
          next_state = FILL;
        end
        if (pix_req) begin
          rgb_we = 1'b1;
        end
      end
      FILL: begin
        wr_en = accept;
        if (pix_req) begin
          rgb_we = 1'b1;
          if (pix_sof && (level >= THRESH_L) && head_sof) begin
            pop        = 1'b1;
            rgb_next   = head_data;
            next_state = RUN;
          end
        end
      end
      RUN: begin
        wr_en = accept;
        if (pix_req) begin
          rgb_we = 1'b1;
          if (level == '0) begin
            set_uf = 1'b1;
          end else if (head_sof != pix_sof) begin
            set_se     = 1'b1;
            flush      = 1'b1;
            wr_en      = 1'b0;
            next_state = WAIT_SOF;
          end else begin
            pop      = 1'b1;
            rgb_next = head_data;
          end
        end
      end
      default: begin
        next_state = WAIT_SOF;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state <= WAIT_SOF;
    end else begin
      state <= next_state;
    end
  end

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge pixel_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {in_sof, in_data};
    end
  end

  // Pointers and occupancy; a flush empties the buffer in a single cycle.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Registered pixel output; blank unless a real pixel is popped, held when idle.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      pix_rgb <= '0;
    end else if (rgb_we) begin
      pix_rgb <= rgb_next;
    end
  end

  // Sticky error flags; a new error in the same cycle beats a clear request.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (set_uf) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
      if (set_se) begin
        sync_err <= 1'b1;
      end else if (err_clr) begin
        sync_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb_vga_pixel_fifo: directed scenarios plus randomized traffic for vga_pixel_fifo,
// checked every cycle against a queue-based reference of the buffer behaviour.
module tb_vga_pixel_fifo;

  localparam int DEPTH  = 256;
  localparam int DW     = 24;
  localparam int THRESH = 128;
  localparam int FRAME  = 150;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          pix_req = 1'b0;
  logic          pix_sof = 1'b0;
  logic [DW-1:0] pix_rgb;
  logic [8:0]    level;
  logic          underflow;
  logic          sync_err;
  logic          err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {M_WAIT, M_FILL, M_RUN} mode_t;

  // Reference: a queue of {sof,data} words plus the current frame mode and outputs.
  logic [DW:0]   ref_q[$];
  mode_t         ref_mode = M_WAIT;
  logic [DW-1:0] ref_rgb = '0;
  logic          ref_uf = 1'b0;
  logic          ref_se = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_pixel_fifo #(.DEPTH(DEPTH), .DW(DW), .THRESH(THRESH)) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst_n(pixel_rst_n),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pix_req    (pix_req),
    .pix_sof    (pix_sof),
    .pix_rgb    (pix_rgb),
    .level      (level),
    .underflow  (underflow),
    .sync_err   (sync_err),
    .err_clr    (err_clr)
  );

  function automatic logic ref_ready();
    return (ref_mode == M_WAIT) || (ref_q.size() != DEPTH);
  endfunction

  task automatic ref_reset();
    ref_q.delete();
    ref_mode = M_WAIT;
    ref_rgb  = '0;
    ref_uf   = 1'b0;
    ref_se   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    checkOutput("in_ready",  32'(in_ready),  32'(ref_ready()));
    checkOutput("level",     32'(level),     32'(ref_q.size()));
    checkOutput("pix_rgb",   32'(pix_rgb),   32'(ref_rgb));
    checkOutput("underflow", 32'(underflow), 32'(ref_uf));
    checkOutput("sync_err",  32'(sync_err),  32'(ref_se));
  endtask

  // Drive one cycle of inputs, advance the reference across the edge, then compare.
  task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d,
                               input logic rq, input logic rs, input logic ec);
    logic acc, wr, pop, flush, suf, sse;
    logic [DW-1:0] nrgb;
    mode_t nmode;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    pix_req  = rq;
    pix_sof  = rs;
    err_clr  = ec;
    acc   = v && ref_ready();
    wr    = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    suf   = 1'b0;
    sse   = 1'b0;
    nrgb  = ref_rgb;
    nmode = ref_mode;
    if (ref_mode == M_WAIT) begin
      if (acc && s) begin
        wr    = 1'b1;
        nmode = M_FILL;
      end
      if (rq) nrgb = '0;
    end else if (ref_mode == M_FILL) begin
      wr = acc;
      if (rq) begin
        if (rs && ref_q.size() >= THRESH && ref_q[0][DW]) begin
          pop   = 1'b1;
          nrgb  = ref_q[0][DW-1:0];
          nmode = M_RUN;
        end else begin
          nrgb = '0;
        end
      end
    end else begin
      wr = acc;
      if (rq) begin
        nrgb = '0;
        if (ref_q.size() == 0) begin
          suf = 1'b1;
        end else if (ref_q[0][DW] != rs) begin
          sse   = 1'b1;
          flush = 1'b1;
          nmode = M_WAIT;
        end else begin
          pop  = 1'b1;
          nrgb = ref_q[0][DW-1:0];
        end
      end
    end
    @(posedge pixel_clk);
    #1;
    if (flush) begin
      ref_q.delete();
    end else begin
      if (pop) void'(ref_q.pop_front());
      if (wr) ref_q.push_back({s, d});
    end
    ref_mode = nmode;
    ref_rgb  = nrgb;
    ref_uf   = suf ? 1'b1 : (ec ? 1'b0 : ref_uf);
    ref_se   = sse ? 1'b1 : (ec ? 1'b0 : ref_se);
    check_all();
  endtask

  task automatic push_word(input logic s, input logic [DW-1:0] d);
    applyStimulus(1'b1, s, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pull_pixel(input logic rs, input logic ec);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, rs, ec);
  endtask

  initial begin
    int src_cnt;
    int pix_cnt;
    int pv, pr;
    logic v, s, rq, rs, ec;

    #12;
    pixel_rst_n = 1'b1;
    #1;
    checkOutput("rst_level",  32'(level),    32'd0);
    checkOutput("rst_ready",  32'(in_ready), 32'd1);
    checkOutput("rst_rgb",    32'(pix_rgb),  32'd0);
    checkOutput("rst_flags",  32'({underflow, sync_err}), 32'd0);

    // Non-sof words are dropped before a frame start.
    for (int i = 0; i < 3; i++) push_word(1'b0, DW'($urandom));
    checkOutput("t1_level_drop", 32'(level), 32'd0);
    push_word(1'b1, 24'h112233);
    checkOutput("t1_level", 32'(level), 32'd1);

    // Fill to threshold then start the frame.
    for (int i = 0; i < THRESH - 1; i++) push_word(1'b0, DW'($urandom));
    checkOutput("t2_level_full", 32'(level), 32'd128);
    pull_pixel(1'b1, 1'b0);
    checkOutput("t2_rgb",   32'(pix_rgb), 32'h112233);
    checkOutput("t2_level", 32'(level),   32'd127);

    // Drain completely, then underflow while a clear is also requested.
    for (int i = 0; i < THRESH - 1; i++) pull_pixel(1'b0, 1'b0);
    checkOutput("t3_level", 32'(level), 32'd0);
    pull_pixel(1'b0, 1'b1);
    checkOutput("t3_rgb", 32'(pix_rgb),   32'd0);
    checkOutput("t3_uf",  32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_uf_clr", 32'(underflow), 32'd0);

    // Misalignment: sof at head while the timing stage is mid-frame.
    push_word(1'b1, DW'($urandom));
    pull_pixel(1'b0, 1'b0);
    checkOutput("t4_se",    32'(sync_err), 32'd1);
    checkOutput("t4_level", 32'(level),    32'd0);
    checkOutput("t4_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_se_clr", 32'(sync_err), 32'd0);

    // Fill to capacity; a simultaneous write is refused while the pop proceeds.
    push_word(1'b1, DW'($urandom));
    for (int i = 0; i < DEPTH - 1; i++) push_word(1'b0, DW'($urandom));
    checkOutput("t5_level", 32'(level),    32'd256);
    checkOutput("t5_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, DW'($urandom), 1'b1, 1'b1, 1'b0);
    checkOutput("t5_level_pop", 32'(level),    32'd255);
    checkOutput("t5_ready_pop", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a running frame.
    for (int i = 0; i < 205; i++) pull_pixel(1'b0, 1'b0);
    checkOutput("t6_level_pre", 32'(level), 32'd50);
    pixel_rst_n = 1'b0;
    #2;
    checkOutput("t6_level", 32'(level),   32'd0);
    checkOutput("t6_rgb",   32'(pix_rgb), 32'd0);
    checkOutput("t6_flags", 32'({underflow, sync_err}), 32'd0);
    checkOutput("t6_ready", 32'(in_ready), 32'd1);
    ref_reset();
    #2;
    pixel_rst_n = 1'b1;
    push_word(1'b0, DW'($urandom));
    checkOutput("t6_wait_drop", 32'(level), 32'd0);

    // Randomized traffic in phases biased toward full, empty and balanced operation.
    src_cnt = 0;
    pix_cnt = 0;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pv = 90; pr = 30; end
        1:       begin pv = 30; pr = 90; end
        2:       begin pv = 60; pr = 60; end
        default: begin pv = 95; pr = 95; end
      endcase
      for (int c = 0; c < 800; c++) begin
        v  = ($urandom_range(0, 99) < pv);
        s  = (src_cnt == 0) || ($urandom_range(0, 199) == 0);
        rq = ($urandom_range(0, 99) < pr);
        rs = (pix_cnt == 0) || ($urandom_range(0, 199) == 0);
        ec = ($urandom_range(0, 49) == 0);
        if (v && ref_ready()) src_cnt = (src_cnt == FRAME - 1) ? 0 : src_cnt + 1;
        if (rq) pix_cnt = (pix_cnt == FRAME - 1) ? 0 : pix_cnt + 1;
        applyStimulus(v, s, DW'($urandom), rq, rs, ec);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
